// File: rtl/bram_debug_pkg.sv
// Shared types and constants for the BRAM debug loader: command opcodes,
// controller states and the debug-port data width.
package bram_debug_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_DUMP = 2'd1,
        OP_RUN  = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_DUMP_ADDR = 3'd2,
        ST_DUMP_WAIT = 3'd3,
        ST_DUMP_OUT  = 3'd4,
        ST_RUN       = 3'd5,
        ST_FIN       = 3'd6
    } state_e;

endpackage

// File: rtl/bram_debug_chan_mux.sv
// Fans the single internal debug port out to one of CHANNELS BRAM ports and
// returns the read data of the selected port. Unselected ports stay at zero.
module bram_debug_chan_mux
    import bram_debug_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int SEL_W    = 1
) (
    input  logic [SEL_W-1:0]           i_sel,
    input  logic                       i_en,
    input  logic [DATA_W-1:0]          i_a,
    input  logic [DATA_W-1:0]          i_wd,
    input  logic [BE_W-1:0]            i_we,
    output logic [DATA_W*CHANNELS-1:0] o_dbg_a,
    output logic [DATA_W*CHANNELS-1:0] o_dbg_wd,
    output logic [BE_W*CHANNELS-1:0]  o_dbg_we,
    input  logic [DATA_W*CHANNELS-1:0] i_dbg_rd,
    output logic [DATA_W-1:0]          o_rd
);

    // route the port to the selected channel, zero everywhere else
    always_comb begin
        o_dbg_a  = '0;
        o_dbg_wd = '0;
        o_dbg_we = '0;
        o_rd     = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (i_en && (int'(i_sel) == ch)) begin
                o_dbg_a[ch*DATA_W +: DATA_W] = i_a;
                o_dbg_wd[ch*DATA_W +: DATA_W] = i_wd;
                o_dbg_we[ch*BE_W +: BE_W]    = i_we;
                o_rd                         = i_dbg_rd[ch*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/bram_debug_loader.sv
// Debug loader for the core's cache BRAMs: loads a word stream into a
// channel, dumps a channel back out as a stream, or pulses the core reset.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | waiting for a command, cmd_ready high
// ST_LOAD      | accepting input beats; each beat is written one cycle later
// ST_DUMP_ADDR | presenting word address to the BRAM
// ST_DUMP_WAIT | waiting RD_LAT cycles for read data, captured on the last
// ST_DUMP_OUT  | holding the captured word on the output stream
// ST_RUN       | core reset asserted for RST_CYC cycles
// ST_FIN       | one-cycle done pulse
module bram_debug_loader
    import bram_debug_pkg::*;
#(
    parameter int WORDS    = 4096,
    parameter int CHANNELS = 2,
    parameter int RD_LAT   = 2,
    parameter int RST_CYC  = 5,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int LEN_W   = $clog2(WORDS) + 1
) (
    input  logic                       i_cpu_clk,
    input  logic                       i_cpu_rst,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic [1:0]                 i_cmd_op,
    input  logic [CH_W-1:0]            i_cmd_chan,
    input  logic [LEN_W-1:0]           i_cmd_len,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic [DATA_W-1:0]          i_in_data,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [DATA_W-1:0]          o_out_data,
    output logic                       o_out_last,
    output logic [DATA_W*CHANNELS-1:0] o_dbg_a,
    output logic [DATA_W*CHANNELS-1:0] o_dbg_wd,
    output logic [BE_W*CHANNELS-1:0]  o_dbg_we,
    input  logic [DATA_W*CHANNELS-1:0] i_dbg_rd,
    output logic                       o_core_rst,
    output logic                       o_busy,
    output logic                       o_done
);

    state_e              r_state;
    state_e              w_state_nxt;
    op_e                 r_op;
    logic [CH_W-1:0]     r_chan;
    logic                r_chan_ok;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_idx;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_wr_pend;
    logic [DATA_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_cmd_ready;
    logic                r_out_valid;
    logic                r_out_last;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_core_rst;
    logic                r_busy;
    logic                r_done;

    logic                w_cmd_fire;
    logic                w_beat_fire;
    logic                w_out_fire;
    logic                w_in_ready;
    logic                w_chan_ok;
    logic                w_noop;
    logic [LEN_W-1:0]    w_len_clamped;
    logic                w_dump_addr;
    logic [DATA_W-1:0]   w_port_a;
    logic [DATA_W-1:0]   w_port_wd;
    logic [BE_W-1:0]     w_port_we;
    logic [DATA_W-1:0]   w_rd;

    // command decode: clamp the length and spot commands that do nothing
    always_comb begin
        w_len_clamped = (i_cmd_len > LEN_W'(WORDS)) ? LEN_W'(WORDS) : i_cmd_len;
        w_chan_ok     = (32'(i_cmd_chan) < 32'(CHANNELS));
        // RUN does not touch the BRAMs, so only the reserved op makes it a no-op
        w_noop        = (i_cmd_op == OP_RSVD) ||
                        ((i_cmd_op != OP_RUN) && ((w_len_clamped == '0) || !w_chan_ok));
    end

    // next-state logic and stream handshakes
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_fire  = i_cmd_valid && r_cmd_ready;
        w_in_ready  = (r_state == ST_LOAD) && (r_idx < r_len);
        w_beat_fire = w_in_ready && i_in_valid;
        w_out_fire  = (r_state == ST_DUMP_OUT) && r_out_valid && i_out_ready;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_fire) begin
                    if (w_noop) begin
                        w_state_nxt = ST_FIN;
                    end else begin
                        case (op_e'(i_cmd_op))
                            OP_LOAD: w_state_nxt = ST_LOAD;
                            OP_DUMP: w_state_nxt = ST_DUMP_ADDR;
                            default: w_state_nxt = ST_RUN;
                        endcase
                    end
                end
            end
            // leave only once the last beat's write is on the port
            ST_LOAD:      if (r_idx >= r_len) w_state_nxt = ST_FIN;
            ST_DUMP_ADDR: w_state_nxt = ST_DUMP_WAIT;
            ST_DUMP_WAIT: if (r_cnt == '0) w_state_nxt = ST_DUMP_OUT;
            ST_DUMP_OUT: begin
                if (w_out_fire) w_state_nxt = r_out_last ? ST_FIN : ST_DUMP_ADDR;
            end
            ST_RUN:       if (r_cnt == '0) w_state_nxt = ST_FIN;
            ST_FIN:       w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge i_cpu_clk or posedge i_cpu_rst) begin
        if (i_cpu_rst) r_state <= ST_IDLE;
        else           r_state <= w_state_nxt;
    end

    // status outputs registered from the next state so they track r_state
    always_ff @(posedge i_cpu_clk or posedge i_cpu_rst) begin
        if (i_cpu_rst) begin
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_core_rst  <= 1'b0;
        end else begin
            r_cmd_ready <= (w_state_nxt == ST_IDLE);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= (w_state_nxt == ST_FIN);
            r_core_rst  <= (w_state_nxt == ST_RUN);
        end
    end

    // down-counter for the reset pulse width and the read latency
    always_ff @(posedge i_cpu_clk or posedge i_cpu_rst) begin
        if (i_cpu_rst) begin
            r_cnt <= '0;
        end else if ((r_state == ST_IDLE) && (w_state_nxt == ST_RUN)) begin
            r_cnt <= CNT_W'(RST_CYC - 1);
        end else if (r_state == ST_DUMP_ADDR) begin
            r_cnt <= CNT_W'(RD_LAT - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // command latch, word index, write staging and output capture
    always_ff @(posedge i_cpu_clk or posedge i_cpu_rst) begin
        if (i_cpu_rst) begin
            r_op        <= OP_LOAD;
            r_chan      <= '0;
            r_chan_ok   <= 1'b0;
            r_len       <= '0;
            r_idx       <= '0;
            r_wr_pend   <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_wr_pend <= 1'b0;
            if (w_cmd_fire) begin
                r_op      <= op_e'(i_cmd_op);
                r_chan    <= i_cmd_chan;
                r_chan_ok <= w_chan_ok;
                r_len     <= w_len_clamped;
                r_idx     <= '0;
            end
            if (w_beat_fire) begin
                r_wr_pend <= 1'b1;
                r_wr_addr <= DATA_W'({r_idx, 2'b00});
                r_wr_data <= i_in_data;
                r_idx     <= r_idx + LEN_W'(1);
            end
            if ((r_state == ST_DUMP_WAIT) && (r_cnt == '0)) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_rd;
                r_out_last  <= (r_idx == (r_len - LEN_W'(1)));
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                r_idx       <= r_idx + LEN_W'(1);
            end
        end
    end

    // internal port: read address during a dump, staged write otherwise
    always_comb begin
        w_dump_addr = (r_state == ST_DUMP_ADDR) || (r_state == ST_DUMP_WAIT);
        w_port_a    = '0;
        if (w_dump_addr)    w_port_a = DATA_W'({r_idx, 2'b00});
        else if (r_wr_pend) w_port_a = r_wr_addr;
        w_port_wd   = r_wr_pend ? r_wr_data : '0;
        w_port_we   = {BE_W{r_wr_pend}};
    end

    bram_debug_chan_mux #(
        .CHANNELS (CHANNELS),
        .SEL_W    (CH_W)
    ) u_chan_mux (
        .i_sel    (r_chan),
        .i_en     (r_chan_ok),
        .i_a      (w_port_a),
        .i_wd     (w_port_wd),
        .i_we     (w_port_we),
        .o_dbg_a  (o_dbg_a),
        .o_dbg_wd (o_dbg_wd),
        .o_dbg_we (o_dbg_we),
        .i_dbg_rd (i_dbg_rd),
        .o_rd     (w_rd)
    );

    assign o_cmd_ready = r_cmd_ready;
    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_last  = r_out_last;
    assign o_core_rst  = r_core_rst;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_bram_debug_loader.sv
// Bench for bram_debug_loader: BRAM model with two-cycle read latency,
// scoreboard queues for expected writes and expected dump beats.
module tb_bram_debug_loader;
    import bram_debug_pkg::*;

    localparam int WORDS    = 4096;
    localparam int CHANNELS = 2;
    localparam int CH_W     = 1;
    localparam int LEN_W    = 13;
    localparam int AW       = 12;

    typedef struct {
        int          ch;
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic [31:0] d;
        logic        last;
    } out_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [CH_W-1:0]       cmd_chan;
    logic [LEN_W-1:0]      cmd_len;
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_data;
    logic                  out_last;
    logic [32*CHANNELS-1:0] dbg_a;
    logic [32*CHANNELS-1:0] dbg_wd;
    logic [4*CHANNELS-1:0]  dbg_we;
    logic [32*CHANNELS-1:0] dbg_rd;
    logic                  core_rst;
    logic                  busy;
    logic                  done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int cur_ch   = 0;
    int wr_cnt   = 0;
    int last_wr_cyc = 0;
    logic [31:0] last_wr_addr = '0;

    wr_t  exp_wr[$];
    out_t exp_out[$];
    logic [31:0] ld[$];

    logic [31:0] mem [CHANNELS][WORDS];
    logic [31:0] rd_p1 [CHANNELS];
    logic [31:0] rd_p2 [CHANNELS];

    bram_debug_loader dut (
        .i_cpu_clk   (clk),
        .i_cpu_rst   (rst),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_op    (cmd_op),
        .i_cmd_chan  (cmd_chan),
        .i_cmd_len   (cmd_len),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_out_last  (out_last),
        .o_dbg_a     (dbg_a),
        .o_dbg_wd    (dbg_wd),
        .o_dbg_we    (dbg_we),
        .i_dbg_rd    (dbg_rd),
        .o_core_rst  (core_rst),
        .o_busy      (busy),
        .o_done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: byte-enable write, read data two cycles after the address
    always @(posedge clk) begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (dbg_we[ch*4 +: 4] == 4'hF)
                mem[ch][dbg_a[ch*32+2 +: AW]] <= dbg_wd[ch*32 +: 32];
            rd_p1[ch] <= mem[ch][dbg_a[ch*32+2 +: AW]];
            rd_p2[ch] <= rd_p1[ch];
        end
    end

    always_comb begin
        dbg_rd = '0;
        for (int ch = 0; ch < CHANNELS; ch++) dbg_rd[ch*32 +: 32] = rd_p2[ch];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // monitor: pop the scoreboards whenever the DUT writes or emits a beat
    wr_t  m_wr;
    out_t m_out;
    always @(negedge clk) begin
        if (!rst) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if ((ch != cur_ch) &&
                    ((dbg_we[ch*4 +: 4] != 0) || (dbg_a[ch*32 +: 32] != 0) || (dbg_wd[ch*32 +: 32] != 0)))
                    chk("nonsel_zero", {dbg_we[ch*4 +: 4], dbg_a[ch*32 +: 32]}, 0);
                if (dbg_we[ch*4 +: 4] != 0) begin
                    wr_cnt++;
                    last_wr_cyc  = cyc;
                    last_wr_addr = dbg_a[ch*32 +: 32];
                    if (exp_wr.size() == 0) begin
                        chk("wr_unexpected", dbg_we[ch*4 +: 4], 0);
                    end else begin
                        m_wr = exp_wr.pop_front();
                        chk("wr_chan", ch, m_wr.ch);
                        chk("wr_addr", dbg_a[ch*32 +: 32], m_wr.a);
                        chk("wr_data", dbg_wd[ch*32 +: 32], m_wr.d);
                        chk("wr_we", dbg_we[ch*4 +: 4], 4'hF);
                    end
                end
            end
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) begin
                    chk("out_unexpected", out_data, 0);
                end else begin
                    m_out = exp_out.pop_front();
                    chk("out_data", out_data, m_out.d);
                    chk("out_last", out_last, m_out.last);
                end
            end
        end
    end

    task automatic send_cmd(input logic [1:0] op, input int ch, input int len, output int acc);
        int t;
        t = 0;
        cur_ch    = ch;
        cmd_op    = op;
        cmd_chan  = CH_W'(ch);
        cmd_len   = LEN_W'(len);
        cmd_valid = 1'b1;
        while (!cmd_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
        @(posedge clk); #1;
        acc       = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic push_beats(input int ch, input int n);
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            in_valid = 1'b1;
            in_data  = ld[i];
            @(negedge clk);
            while (!in_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                chk("in_ready_timeout", 0, 1);
                break;
            end
            exp_wr.push_back('{ch, 32'(i * 4), ld[i]});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        int t;
        t    = 0;
        dcyc = -1;
        while (t < budget) begin
            @(negedge clk);
            if (done) begin
                dcyc = cyc;
                break;
            end
            t++;
        end
        if (dcyc < 0) chk("done_timeout", 0, 1);
    endtask

    function automatic logic [31:0] big_pat(input int i);
        return 32'h5A00_0000 ^ (32'(i) * 32'd2654435761);
    endfunction

    initial begin
        #600000;
        $display("FAIL watchdog got=hang exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, dcyc, w0, first_rst, n_rst, t;

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_chan = '0; cmd_len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ctl", {cmd_ready, in_ready, out_valid, out_last, core_rst, busy, done}, 0);
        chk("rst_dbg", {|dbg_a, |dbg_wd, |dbg_we, |out_data}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_ready", {cmd_ready, busy}, 2'b10);

        // LOAD chan0, three words
        ld = '{32'h11, 32'h22, 32'h33};
        w0 = wr_cnt;
        send_cmd(OP_LOAD, 0, 3, acc);
        push_beats(0, 3);
        wait_done(50, dcyc);
        chk("load3_done_lat", dcyc - last_wr_cyc, 1);
        chk("load3_writes", wr_cnt - w0, 3);
        chk("load3_drained", exp_wr.size(), 0);

        // LOAD chan1 with AA, BB for the dump
        ld = '{32'hAA, 32'hBB};
        send_cmd(OP_LOAD, 1, 2, acc);
        push_beats(1, 2);
        wait_done(50, dcyc);

        // DUMP chan1 with back-pressure on the first word
        exp_out.push_back('{32'hAA, 1'b0});
        exp_out.push_back('{32'hBB, 1'b1});
        send_cmd(OP_DUMP, 1, 2, acc);
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("dump_first_valid", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            chk("dump_hold", {out_valid, out_last, out_data}, {1'b1, 1'b0, 32'hAA});
            if (i < 4) @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done(50, dcyc);
        out_ready = 1'b0;
        chk("dump_drained", exp_out.size(), 0);

        // RUN: core reset for five cycles, done on the sixth
        send_cmd(OP_RUN, 0, 1, acc);
        first_rst = -1; n_rst = 0; dcyc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (core_rst) begin
                if (first_rst < 0) first_rst = cyc;
                n_rst++;
            end
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        chk("run_rst_start", first_rst, acc);
        chk("run_rst_width", n_rst, 5);
        chk("run_done_cyc", dcyc, acc + 5);
        @(negedge clk);
        chk("run_ready_back", {cmd_ready, busy, core_rst}, 3'b100);

        // no-op commands: FIN is the first cycle after acceptance, no writes
        w0 = wr_cnt;
        in_valid = 1'b1;
        send_cmd(OP_LOAD, 1, 0, acc);
        wait_done(10, dcyc);
        chk("len0_done_cyc", dcyc, acc);
        send_cmd(OP_RSVD, 0, 4, acc);
        wait_done(10, dcyc);
        chk("rsvd_done_cyc", dcyc, acc);
        in_valid = 1'b0;
        chk("noop_no_writes", wr_cnt - w0, 0);

        // LOAD with len above WORDS is clamped
        ld.delete();
        for (int i = 0; i < WORDS; i++) ld.push_back(big_pat(i));
        w0 = wr_cnt;
        send_cmd(OP_LOAD, 0, 5000, acc);
        push_beats(0, WORDS);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("clamp_in_ready", in_ready, 0);
        wait_done(20, dcyc);
        in_valid = 1'b0;
        chk("clamp_writes", wr_cnt - w0, WORDS);
        chk("clamp_last_addr", last_wr_addr, 32'h3FFC);

        // reset after two of four beats
        ld = '{32'h101, 32'h102, 32'h103, 32'h104};
        w0 = wr_cnt;
        send_cmd(OP_LOAD, 0, 4, acc);
        push_beats(0, 2);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 32'h103;
        rst      = 1'b1;
        @(negedge clk);
        chk("midrst_ctl", {cmd_ready, in_ready, out_valid, out_last, core_rst, busy, done}, 0);
        chk("midrst_dbg", {|dbg_a, |dbg_wd, |dbg_we, |out_data}, 0);
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_idle", {cmd_ready, busy}, 2'b10);
        chk("midrst_writes", wr_cnt - w0, 2);
        chk("midrst_word0", mem[0][0], 32'h101);
        chk("midrst_word1", mem[0][1], 32'h102);
        chk("midrst_word2", mem[0][2], big_pat(2));
        chk("end_wr_drained", exp_wr.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
